dmem_responder: RTL and testbench

//  Data-memory responder for the Memory_Cycle request port. Replaces the

---
 rtl/dmem_responder_if.sv | 32 +++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bus between the Memory_Cycle stage and dmem_responder.
// DMEM_WSTRB_EN adds the per-byte write strobe signal.
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
`ifdef DMEM_WSTRB_EN
    logic [3:0]  req_wstrb_i;
`endif
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        stall_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
`ifdef DMEM_WSTRB_EN
        input  req_wstrb_i,
`endif
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, stall_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
`ifdef DMEM_WSTRB_EN
        output req_wstrb_i,
`endif
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, stall_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data memory. One access per handshake, response
// LATENCY wait cycles later, stall_o freezes the pipeline meanwhile.
// Optional feature macro: DMEM_WSTRB_EN (per-byte store strobes).
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                clk,
    input  logic                reset,
    dmem_responder_if.slave     bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic          ready, accept, commit;
    logic          c_we, c_err;
    logic [31:0]   c_addr, c_wdata;
    logic [AW-1:0] c_idx;
`ifdef DMEM_WSTRB_EN
    logic [3:0]    wstrb_q, c_wstrb;
`endif

    assign ready  = (state_q != WAIT);
    assign accept = bus.req_valid_i & ready;

    // Next-state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Commit uses the captured request when waiting, the live request when
    // a zero-latency accept goes straight to RESP
    always_comb begin
        c_we    = (state_q == WAIT) ? we_q    : bus.req_we_i;
        c_addr  = (state_q == WAIT) ? addr_q  : bus.req_addr_i;
        c_wdata = (state_q == WAIT) ? wdata_q : bus.req_wdata_i;
`ifdef DMEM_WSTRB_EN
        c_wstrb = (state_q == WAIT) ? wstrb_q : bus.req_wstrb_i;
`endif
        c_idx   = c_addr[2 +: AW];
        c_err   = (c_addr[1:0] != 2'b00) || ((c_addr >> (AW + 2)) != '0);
        commit  = (state_d == RESP) && reset;
    end

    // State, counter and request capture registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DMEM_WSTRB_EN
            wstrb_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we_i;
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
`ifdef DMEM_WSTRB_EN
                wstrb_q <= bus.req_wstrb_i;
`endif
            end
        end
    end

    // Response data/error registered on the edge entering RESP, held after
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            rdata_q <= (!c_we && !c_err) ? mem[c_idx] : '0;
            err_q   <= c_err;
        end
    end

    // Storage array write (not reset, contents survive reset)
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
`ifdef DMEM_WSTRB_EN
            for (int unsigned i = 0; i < 4; i++) begin
                if (c_wstrb[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
`else
            mem[c_idx] <= c_wdata;
`endif
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.stall_o     = (state_q == WAIT) | accept;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for most tests,
// LATENCY=0 instance for the back-to-back stream.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on the LATENCY=2 instance; returns response and timing
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input bit toggle, output logic [31:0] rd, output logic er,
                        output int lat, output int stalls);
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wd;
        bus.req_valid_i = 1'b1;
        #1;
        stalls = int'(bus.stall_o);
        lat = -1;
        rd  = 'x;
        er  = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 1)      bus.req_valid_i = toggle;
            else if (n == 2) bus.req_valid_i = 1'b0;
            #1;
            stalls += int'(bus.stall_o);
            if (bus.rsp_valid_o) begin
                lat = n;
                rd  = bus.rsp_rdata_o;
                er  = bus.rsp_err_o;
                break;
            end
        end
        bus.req_valid_i = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, st, extra;

        reset = 1'b0;
        bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
        bus0.req_valid_i = 0; bus0.req_we_i = 0; bus0.req_addr_i = '0; bus0.req_wdata_i = '0;
`ifdef DMEM_WSTRB_EN
        bus.req_wstrb_i = 4'hF;
        bus0.req_wstrb_i = 4'hF;
`endif
        tick(); tick();
        chk("rst_ready", bus.req_ready_o, 1);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rdata", bus.rsp_rdata_o, 0);
        chk("rst_err", bus.rsp_err_o, 0);
        chk("rst_stall", bus.stall_o, 0);
        reset = 1'b1;
        tick();

        // T2: store then load, latency and stall
        xact(1'b1, 32'h40, 32'h12345678, 1'b0, rd, er, lat, st);
        chk("t2_st_lat", lat, 3);
        chk("t2_st_err", er, 0);
        chk("t2_st_rdata", rd, 0);
        chk("t2_st_stalls", st, 3);
        xact(1'b0, 32'h40, 32'h0, 1'b0, rd, er, lat, st);
        chk("t2_ld_lat", lat, 3);
        chk("t2_ld_rdata", rd, 32'h12345678);
        chk("t2_ld_err", er, 0);
        chk("t2_ld_stalls", st, 3);

        // T1: reset during WAIT of a store
        xact(1'b1, 32'h10, 32'h0BADF00D, 1'b0, rd, er, lat, st);
        xact(1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, st);
        chk("t1_pre_rdata", rd, 32'h0BADF00D);
        bus.req_we_i = 1'b1; bus.req_addr_i = 32'h10; bus.req_wdata_i = 32'hDEADBEEF;
        bus.req_valid_i = 1'b1;
        tick();
        bus.req_valid_i = 1'b0;
        #1;
        chk("t1_wait_stall", bus.stall_o, 1);
        chk("t1_wait_ready", bus.req_ready_o, 0);
        reset = 1'b0;
        #1;
        chk("t1_rst_ready", bus.req_ready_o, 1);
        chk("t1_rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("t1_rst_rdata", bus.rsp_rdata_o, 0);
        chk("t1_rst_err", bus.rsp_err_o, 0);
        chk("t1_rst_stall", bus.stall_o, 0);
        tick();
        chk("t1_rst_next_rsp", bus.rsp_valid_o, 0);
        reset = 1'b1;
        extra = 0;
        repeat (4) begin
            tick();
            if (bus.rsp_valid_o) extra++;
        end
        chk("t1_no_stale_rsp", extra, 0);
        xact(1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, st);
        chk("t1_ld_prior", rd, 32'h0BADF00D);

        // T4: misaligned and out-of-range accesses
        xact(1'b1, 32'h0, 32'hCAFEF00D, 1'b0, rd, er, lat, st);
        xact(1'b0, 32'h42, 32'h0, 1'b0, rd, er, lat, st);
        chk("t4_mis_err", er, 1);
        chk("t4_mis_rdata", rd, 0);
        xact(1'b0, 32'h1000, 32'h0, 1'b0, rd, er, lat, st);
        chk("t4_oor_err", er, 1);
        chk("t4_oor_rdata", rd, 0);
        xact(1'b1, 32'h1000, 32'hFFFFFFFF, 1'b0, rd, er, lat, st);
        chk("t4_oor_st_err", er, 1);
        xact(1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat, st);
        chk("t4_word0_kept", rd, 32'hCAFEF00D);
        chk("t4_word0_err", er, 0);
        xact(1'b1, 32'hFFC, 32'h55AA55AA, 1'b0, rd, er, lat, st);
        chk("t4_top_st_err", er, 0);
        xact(1'b0, 32'hFFC, 32'h0, 1'b0, rd, er, lat, st);
        chk("t4_top_ld", rd, 32'h55AA55AA);

        // T5: valid toggled during WAIT is ignored
        xact(1'b0, 32'h40, 32'h0, 1'b1, rd, er, lat, st);
        chk("t5_lat", lat, 3);
        chk("t5_rdata", rd, 32'h12345678);
        extra = 0;
        repeat (6) begin
            if (bus.rsp_valid_o) extra++;
            tick();
        end
        chk("t5_extra_rsp", extra, 0);
        chk("t5_rdata_hold", bus.rsp_rdata_o, 32'h12345678);

        // T3: LATENCY=0 stream held valid
        bus0.req_we_i = 1'b1; bus0.req_addr_i = 32'h8; bus0.req_wdata_i = 32'h00000077;
        bus0.req_valid_i = 1'b1;
        #1;
        chk("t3_idle_stall", bus0.stall_o, 1);
        tick();
        chk("t3_st_rsp", bus0.rsp_valid_o, 1);
        chk("t3_st_rdata", bus0.rsp_rdata_o, 0);
        chk("t3_resp_accept_stall", bus0.stall_o, 1);
        bus0.req_we_i = 1'b0;
        tick();
        chk("t3_ld_rsp", bus0.rsp_valid_o, 1);
        chk("t3_ld_rdata", bus0.rsp_rdata_o, 32'h00000077);
        bus0.req_valid_i = 1'b0;
        #1;
        chk("t3_resp_idle_stall", bus0.stall_o, 0);
        tick();
        chk("t3_idle_rsp", bus0.rsp_valid_o, 0);
        chk("t3_rdata_hold", bus0.rsp_rdata_o, 32'h00000077);

`ifdef DMEM_WSTRB_EN
        // T6: partial-lane stores
        bus.req_wstrb_i = 4'hF;
        xact(1'b1, 32'h0, 32'hAABBCCDD, 1'b0, rd, er, lat, st);
        bus.req_wstrb_i = 4'b0101;
        xact(1'b1, 32'h0, 32'h11223344, 1'b0, rd, er, lat, st);
        xact(1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat, st);
        chk("t6_lanes", rd, 32'hAA22CC44);
        bus.req_wstrb_i = 4'b0000;
        xact(1'b1, 32'h0, 32'hFFFFFFFF, 1'b0, rd, er, lat, st);
        chk("t6_zero_strb_err", er, 0);
        xact(1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat, st);
        chk("t6_zero_strb_noop", rd, 32'hAA22CC44);
        bus.req_wstrb_i = 4'hF;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
